// File: rtl/cnt_pkg.sv
// Shared constants for the counter sequencing controller: state encoding,
// mode/direction codes and the default counter width.
package cnt_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/cnt_seq_ctrl_core.sv
// W-bit loadable up/down counter; load takes priority over count enable.
module cnt_core
  import cnt_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         en,
  input  logic         load,
  input  logic         dir,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (en) begin
      q <= (dir == DIR_DOWN) ? (q - ONE) : (q + ONE);
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Timer sequencer around cnt_core: start/stop/pause, one-shot or auto-reload,
// with configuration captured only when a start is accepted.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | stopped, q=0, waiting for start
//   ST_RUN  | counting from S towards T, done pulse at terminal
//   ST_HOLD | paused, q frozen until pause drops
//   ST_DONE | one-shot finished, q holds T until start or stop
module cnt_seq_ctrl
  import cnt_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         mode,
  input  logic         dir,
  input  logic [W-1:0] limit,
  output logic [W-1:0] q,
  output logic         busy,
  output logic         done
);

  state_t       state, state_nxt;
  logic         cfg_mode, cfg_dir;
  logic [W-1:0] cfg_limit;
  logic         latch;
  logic         en, load;
  logic [W-1:0] din;
  logic         busy_nxt, done_nxt;
  logic [W-1:0] start_new, start_cfg, term_cfg;

  // Restart uses the live inputs; reload and terminal compare use the latched copy.
  assign start_new = (dir == DIR_DOWN) ? limit : '0;
  assign start_cfg = (cfg_dir == DIR_DOWN) ? cfg_limit : '0;
  assign term_cfg  = (cfg_dir == DIR_DOWN) ? '0 : cfg_limit;

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    din       = '0;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
      load      = 1'b1;
    end else if (start) begin
      state_nxt = ST_RUN;
      latch     = 1'b1;
      load      = 1'b1;
      din       = start_new;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state_nxt = ST_HOLD;
          end else if (q == term_cfg) begin
            done_nxt = 1'b1;
            if (cfg_mode == MODE_RELOAD) begin
              load = 1'b1;
              din  = start_cfg;
            end else begin
              state_nxt = ST_DONE;
            end
          end else begin
            en = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!pause) state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
    busy_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_mode  <= 1'b0;
      cfg_dir   <= 1'b0;
      cfg_limit <= '0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      if (latch) begin
        cfg_mode  <= mode;
        cfg_dir   <= dir;
        cfg_limit <= limit;
      end
    end
  end

  cnt_core #(.W(W)) u_core (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (en),
    .load  (load),
    .dir   (cfg_dir),
    .din   (din),
    .q     (q)
  );

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
- Sequencing controller for a W-bit loadable up/down counter datapath.
- Turns the free-running counter into a programmable timer with start/stop/pause and terminal detect.
- Supports one-shot and auto-reload modes.
- Sits between control logic (buttons or a bus register) and anything consuming the count value or the period tick.

Parameters:
- W, 4, counter width in bits; all count and limit values are modulo 2^W.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  start/restart request, sampled on the CLK edge.
- stop  input  1  abort request; returns the block to IDLE.
- pause  input  1  level; while high in RUN or HOLD, counting is frozen.
- mode  input  1  0 = one-shot, 1 = auto-reload.
- dir  input  1  0 = count up from 0 to limit, 1 = count down from limit to 0.
- limit  input  W  terminal/start value.
- q  output  W  current count, registered.
- busy  output  1  high in RUN and HOLD, registered.
- done  output  1  one-cycle pulse at terminal count, registered.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, q=0, busy=0, done=0, latched config=0. Reset mid-count aborts immediately; no done pulse is issued.
- Config latch: mode, dir and limit are captured only on an accepted start. Changes while busy are ignored until the next start.
  - Start value S = dir ? limit : 0.
  - Terminal value T = dir ? 0 : limit.
- Priority on the same edge: stop > start > pause.
- States: IDLE, RUN, HOLD, DONE.
- Any state, stop=1: next state IDLE, q<=0, busy<=0, done<=0.
- IDLE/DONE, start=1: q<=S, latch config, next state RUN, busy<=1. Latency: q shows S one cycle after start is sampled.
- RUN, start=1: restart. Re-latch config, q<=S, stay RUN, no done pulse.
- RUN, pause=1: next state HOLD, q unchanged.
- RUN, q!=T: q<=q+1 (up) or q-1 (down), wrapping modulo 2^W.
- RUN, q==T, evaluated on registered q:
  - done<=1 for exactly one cycle.
  - mode=0: q holds T, next state DONE, busy<=0.
  - mode=1: q<=S, stay RUN.
  - Resulting auto-reload period: limit+1 cycles per done pulse.
- HOLD: q frozen, done=0.
  - pause=0: return to RUN and resume from the frozen q.
  - start=1: restart as in RUN.
- DONE: q holds T, busy=0; stays until start or stop.
- limit=0: S==T, so done fires on the first RUN cycle.
  - One-shot: enters DONE one cycle after RUN is entered.
  - Auto-reload: done is high every cycle.
- done is 0 in every cycle not listed above. The default assignment is done<=0.

Decomposition:
- Shared package cnt_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_HOLD, ST_DONE (2-bit);
  - MODE_ONESHOT/MODE_RELOAD;
  - DIR_UP/DIR_DOWN;
  - default width constant CNT_W=4.
- One sub-module, cnt_core: W-bit counter with inputs CLK, RST_N, en, load, dir, din and output q.
  - Priority inside cnt_core: load > en.
  - The FSM in cnt_seq_ctrl drives en/load/din and owns terminal compare, config latch, busy and done.

Test Plan:
1. Reset mid-RUN: W=4, up, limit=9, start, pull RST_N low after 4 cycles -> q=0, busy=0, done=0 immediately (asynchronously); no done pulse.
2. One-shot up: mode=0, dir=0, limit=3, start pulse -> q=0,1,2,3 on consecutive cycles; next cycle done=1 for one cycle, state DONE, q=3, busy=0.
3. Auto-reload down: mode=1, dir=1, limit=2 -> q=2,1,0,2,1,0,...; done high one cycle after each q=0, period 3; busy stays 1.
4. Pause/stop: up, limit=15, pause high for 5 cycles at q=6 -> q stays 6, then resumes 7,8. Assert stop and start on the same edge -> IDLE, q=0, busy=0 (stop wins).
5. Restart and ignored config change: running up to limit=15 at q=10, change limit to 2 without start -> still counts to 15. Then start with limit=2 -> q=0,1,2, done pulse.
6. limit=0 edges: one-shot -> done one cycle after RUN entry, q=0. Auto-reload -> done high continuously while RUN. Also up, limit=15: q runs 0..15 with no spurious wrap before done.
